// File: rtl/vc_input_port.sv
// Router input port: numVC independent flit FIFOs, local XY route, round-robin VC arbiter.
// Pop-to-request is one cycle, then the request is held until granted; sustained rate is one flit per two cycles.
module vc_input_port #(
  parameter int dataWidth    = 32,
  parameter int addressWidth = 2,
  parameter int numVC        = 2,
  parameter int vcWidth      = 1,
  parameter int dim          = 2,
  parameter int curX         = 0,
  parameter int curY         = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reqUpStr,
  input  logic [vcWidth-1:0]   vcUpStr,
  output logic                 gntUpStr,
  output logic [numVC-1:0]     full,
  input  logic [dataWidth-1:0] PacketIn,
  output logic [4:0]           reqOutCntr,
  input  logic [4:0]           gntOutCntr,
  output logic [dataWidth-1:0] PacketOut,
  output logic [vcWidth-1:0]   vcOut
);
  localparam int depth = 1 << addressWidth;

  typedef enum logic {IDLE, REQ} state_t;

  logic [dataWidth-1:0]    mem_q  [numVC][depth];
  logic [addressWidth-1:0] wptr_q [numVC];
  logic [addressWidth-1:0] rptr_q [numVC];
  logic [addressWidth:0]   cnt_q  [numVC];
  logic [addressWidth:0]   cnt_d  [numVC];
  logic [numVC-1:0]        full_q, full_d, wr_v, pop_v;
  logic [(1<<vcWidth)-1:0] full_pad;
  state_t                  state_q;
  logic [vcWidth-1:0]      rr_q, rr_d, sel_vc, vc_q;
  logic                    sel_found, pop;
  logic [4:0]              req_q, route;
  logic [dataWidth-1:0]    pkt_q, head;
  logic [dim-1:0]          dest_x, dest_y;

  // Padding lets an out-of-range VC id index the full vector safely.
  always_comb begin
    full_pad = '0;
    full_pad[numVC-1:0] = full_q;
  end

  assign gntUpStr = reqUpStr && (int'(vcUpStr) < numVC) && !full_pad[vcUpStr];

  always_comb begin : rr_search
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_vc    = '0;
    for (int i = 0; i < numVC; i++) begin
      idx = (int'(rr_q) + i) % numVC;
      if (!sel_found && cnt_q[idx] != '0) begin
        sel_found = 1'b1;
        sel_vc    = vcWidth'(idx);
      end
    end
  end

  assign head   = mem_q[sel_vc][rptr_q[sel_vc]];
  assign dest_y = head[dim-1:0];
  assign dest_x = head[2*dim-1:dim];

  always_comb begin
    if (int'(dest_x) > curX)      route = 5'b00001;
    else if (int'(dest_x) < curX) route = 5'b00100;
    else if (int'(dest_y) > curY) route = 5'b00010;
    else if (int'(dest_y) < curY) route = 5'b01000;
    else                          route = 5'b10000;
  end

  assign pop  = (state_q == IDLE) && sel_found;
  assign rr_d = (int'(sel_vc) == numVC - 1) ? '0 : sel_vc + vcWidth'(1);

  always_comb begin
    for (int v = 0; v < numVC; v++) begin
      wr_v[v]  = gntUpStr && (int'(vcUpStr) == v);
      pop_v[v] = pop && (int'(sel_vc) == v);
      cnt_d[v] = cnt_q[v];
      if (wr_v[v] && !pop_v[v])      cnt_d[v] = cnt_q[v] + (addressWidth+1)'(1);
      else if (!wr_v[v] && pop_v[v]) cnt_d[v] = cnt_q[v] - (addressWidth+1)'(1);
      full_d[v] = (cnt_d[v] == (addressWidth+1)'(depth));
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < numVC; v++)
      if (wr_v[v]) mem_q[v][wptr_q[v]] <= PacketIn;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < numVC; v++) begin
        wptr_q[v] <= '0;
        rptr_q[v] <= '0;
        cnt_q[v]  <= '0;
      end
      full_q <= '0;
    end else begin
      for (int v = 0; v < numVC; v++) begin
        if (wr_v[v])  wptr_q[v] <= wptr_q[v] + addressWidth'(1);
        if (pop_v[v]) rptr_q[v] <= rptr_q[v] + addressWidth'(1);
        cnt_q[v] <= cnt_d[v];
      end
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      req_q   <= '0;
      pkt_q   <= '0;
      vc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (sel_found) begin
          pkt_q   <= head;
          vc_q    <= sel_vc;
          req_q   <= route;
          rr_q    <= rr_d;
          state_q <= REQ;
        end
        REQ: if ((gntOutCntr & req_q) != 5'b0) begin
          req_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign full       = full_q;
  assign reqOutCntr = req_q;
  assign PacketOut  = pkt_q;
  assign vcOut      = vc_q;
endmodule

// File: tb/tb_vc_input_port.sv
// Scoreboard bench for vc_input_port (curX=1, curY=1, 2 VCs, 4-deep FIFOs).
module tb_vc_input_port;
  logic        clk = 1'b0;
  logic        reset;
  logic        reqUpStr;
  logic [0:0]  vcUpStr;
  logic        gntUpStr;
  logic [1:0]  full;
  logic [31:0] PacketIn;
  logic [4:0]  reqOutCntr;
  logic [4:0]  gntOutCntr;
  logic [31:0] PacketOut;
  logic [0:0]  vcOut;

  vc_input_port #(.dataWidth(32), .addressWidth(2), .numVC(2), .vcWidth(1),
                  .dim(2), .curX(1), .curY(1)) dut (
    .clk(clk), .reset(reset), .reqUpStr(reqUpStr), .vcUpStr(vcUpStr),
    .gntUpStr(gntUpStr), .full(full), .PacketIn(PacketIn),
    .reqOutCntr(reqOutCntr), .gntOutCntr(gntOutCntr),
    .PacketOut(PacketOut), .vcOut(vcOut));

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, n_push = 0, n_pop = 0, n_disc = 0;
  logic [31:0] sb0[$], sb1[$];
  logic [4:0]  rseq[$];
  logic [0:0]  vseq[$];
  bit auto_gnt = 1'b0, bad_gnt = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] xy_route(input logic [31:0] d);
    logic [1:0] dx, dy;
    dx = d[3:2];
    dy = d[1:0];
    if (dx > 2'd1)      return 5'b00001;
    else if (dx < 2'd1) return 5'b00100;
    else if (dy > 2'd1) return 5'b00010;
    else if (dy < 2'd1) return 5'b01000;
    else                return 5'b10000;
  endfunction

  // Output-side model: grant whatever is requested and check it against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset) gntOutCntr = 5'b0;
    else if (bad_gnt) gntOutCntr = ~reqOutCntr;
    else if (auto_gnt && reqOutCntr != 5'b0) begin
      if ((vcOut == 1'b0 && sb0.size() == 0) || (vcOut == 1'b1 && sb1.size() == 0))
        chk("spurious_req", {27'b0, reqOutCntr}, 32'h0);
      else begin
        e = (vcOut == 1'b0) ? sb0.pop_front() : sb1.pop_front();
        n_pop++;
        chk("pkt_out", PacketOut, e);
        chk("route", {27'b0, reqOutCntr}, {27'b0, xy_route(e)});
      end
      rseq.push_back(reqOutCntr);
      vseq.push_back(vcOut);
      gntOutCntr = reqOutCntr;
    end else gntOutCntr = 5'b0;
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wr(input int vc, input logic [31:0] d, input logic exp_g, input string tag);
    reqUpStr = 1'b1;
    vcUpStr  = 1'(vc);
    PacketIn = d;
    #1;
    chk(tag, {31'b0, gntUpStr}, {31'b0, exp_g});
    if (gntUpStr) begin
      if (vc == 0) sb0.push_back(d); else sb1.push_back(d);
      n_push++;
    end
    step();
    reqUpStr = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((sb0.size() != 0 || sb1.size() != 0 || reqOutCntr != 5'b0) && k < 200) begin
      step();
      k++;
    end
    chk(tag, sb0.size() + sb1.size() + {27'b0, reqOutCntr}, 32'h0);
  endtask

  function automatic logic [31:0] mk(input logic [1:0] dx, input logic [1:0] dy);
    logic [31:0] r;
    r = $urandom();
    r[3:0] = {dx, dy};
    return r;
  endfunction

  initial begin
    logic [31:0] d1;
    logic [4:0]  exp_r [5];
    logic [0:0]  exp_rr [6];
    logic [0:0]  exp_iso [6];
    logic [31:0] fl [4];
    exp_r   = '{5'b00001, 5'b00100, 5'b00010, 5'b01000, 5'b10000};
    exp_rr  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_iso = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    reset = 1'b1; reqUpStr = 1'b0; vcUpStr = 1'b0; PacketIn = '0;
    step();
    chk("rst_req", {27'b0, reqOutCntr}, 32'h0);
    chk("rst_full", {30'b0, full}, 32'h0);
    chk("rst_pkt", PacketOut, 32'h0);
    chk("rst_vc", {31'b0, vcOut}, 32'h0);
    step();
    reset = 1'b0;
    step();

    // Reset while a flit is held in REQ and another is queued
    d1 = mk(2'd2, 2'd1);
    wr(0, d1, 1'b1, "t1_wr0");
    chk("t1_lat_pre", {27'b0, reqOutCntr}, 32'h0);
    wr(0, mk(2'd0, 2'd0), 1'b1, "t1_wr1");
    chk("t1_lat_req", {27'b0, reqOutCntr}, {27'b0, xy_route(d1)});
    chk("t1_lat_pkt", PacketOut, d1);
    reset = 1'b1;
    #1;
    chk("t1_rst_req", {27'b0, reqOutCntr}, 32'h0);
    chk("t1_rst_full", {30'b0, full}, 32'h0);
    chk("t1_rst_pkt", PacketOut, 32'h0);
    n_disc += sb0.size() + sb1.size();
    sb0.delete(); sb1.delete();
    step();
    reset = 1'b0;
    auto_gnt = 1'b1;
    rseq.delete();
    repeat (8) step();
    chk("t1_no_flit", rseq.size(), 32'h0);

    // XY routing
    rseq.delete();
    wr(0, mk(2'd2, 2'd1), 1'b1, "t2_wr");
    wr(0, mk(2'd0, 2'd1), 1'b1, "t2_wr");
    wr(0, mk(2'd1, 2'd2), 1'b1, "t2_wr");
    wr(0, mk(2'd1, 2'd0), 1'b1, "t2_wr");
    wr(0, mk(2'd1, 2'd1), 1'b1, "t2_wr");
    drain("t2_drain");
    chk("t2_nroutes", rseq.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < rseq.size()) chk($sformatf("t2_route%0d", i), {27'b0, rseq[i]}, {27'b0, exp_r[i]});

    // Fill VC1 while the FSM holds a VC0 flit, then drain and refill to wrap pointers
    auto_gnt = 1'b0;
    step();
    wr(0, mk(2'd3, 2'd3), 1'b1, "t3_wr_vc0");
    for (int i = 0; i < 4; i++) wr(1, mk(2'(i), 2'(3 - i)), 1'b1, "t3_wr_vc1");
    chk("t3_full", {30'b0, full}, 32'h2);
    wr(1, 32'hDEAD_BEEF, 1'b0, "t3_5th_blocked");
    auto_gnt = 1'b1;
    drain("t3_drain1");
    for (int i = 0; i < 4; i++) wr(1, mk(2'(3 - i), 2'(i)), 1'b1, "t3_wrap_wr");
    drain("t3_drain2");

    // Round-robin between two loaded VCs
    auto_gnt = 1'b0;
    step();
    for (int i = 0; i < 3; i++) wr(0, mk(2'(i), 2'd1), 1'b1, "t4_wr0");
    for (int i = 0; i < 3; i++) wr(1, mk(2'd1, 2'(i)), 1'b1, "t4_wr1");
    vseq.delete();
    auto_gnt = 1'b1;
    drain("t4_drain");
    chk("t4_nserved", vseq.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < vseq.size()) chk($sformatf("t4_vc%0d", i), {31'b0, vseq[i]}, {31'b0, exp_rr[i]});

    // VC0 full with its grant withheld; mismatched grant bits must not release it
    auto_gnt = 1'b0;
    step();
    for (int i = 0; i < 4; i++) fl[i] = mk(2'(i), 2'd2);
    d1 = mk(2'd0, 2'd3);
    wr(0, d1, 1'b1, "t5_wrA");
    for (int i = 0; i < 4; i++) wr(0, fl[i], 1'b1, "t5_fill");
    chk("t5_full0", {30'b0, full}, 32'h1);
    bad_gnt = 1'b1;
    step(); step();
    bad_gnt = 1'b0;
    chk("t5_bad_gnt_hold", {27'b0, reqOutCntr}, {27'b0, xy_route(d1)});

    // Grant A once; next cycle VC0 pops while full, so a VC0 write waits a cycle
    auto_gnt = 1'b1;
    step();
    auto_gnt = 1'b0;
    step();
    wr(0, 32'hC0FF_EE05, 1'b0, "t6_same_cycle_blk");
    wr(0, 32'hC0FF_EE05, 1'b1, "t6_next_cycle_gnt");
    chk("t6_full_again", {30'b0, full}, 32'h1);

    wr(1, mk(2'd1, 2'd1), 1'b1, "t5_vc1_gnt");
    chk("t5_full1_low", {30'b0, full}, 32'h1);
    vseq.delete();
    auto_gnt = 1'b1;
    drain("t5_drain");
    chk("t5_nserved", vseq.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < vseq.size()) chk($sformatf("t5_vc%0d", i), {31'b0, vseq[i]}, {31'b0, exp_iso[i]});

    chk("sb_count", n_pop, n_push - n_disc);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
